// File: rtl/cdb_writeback_arbiter.sv
// Result writeback arbiter: one-entry holding buffer per functional unit, round-robin grant onto the CDB.
// Optional same-cycle idle bypass is compiled in when CDB_BYPASS_EN is defined.

package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_tag;
    logic [31:0] value;
  } ex_wr_packet_t;

  localparam int PKT_W = $bits(ex_wr_packet_t);
endpackage

module cdb_writeback_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU  = 3,
  parameter int RR_INIT = 0,
  localparam int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W  = $clog2(NUM_FU + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU*PKT_W-1:0] fu_packet,
  output logic [NUM_FU-1:0]       fu_written,
  output logic [PKT_W-1:0]        cdb_packet,
  output logic [SRC_W-1:0]        cdb_src,
  output logic [CNT_W-1:0]        pending_count
);

  ex_wr_packet_t     in_pkt   [NUM_FU];
  ex_wr_packet_t     hold_pkt [NUM_FU];
  logic [NUM_FU-1:0] hold_valid;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] bypass;
  logic [NUM_FU-1:0] capture;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  sel_idx;

  always_comb begin : unpack
    for (int i = 0; i < NUM_FU; i++) begin
      in_pkt[i] = fu_packet[i*PKT_W +: PKT_W];
    end
  end

  // Round-robin search from rr_ptr; the buffers win, and the idle bypass only looks at inputs
  // when every buffer is empty.
  always_comb begin : arbitrate
    int   idx;
    logic hit;
    logic from_in;
    // NOTE: every variable gets a default before any branch, otherwise partial assignment infers latches.
    idx     = 0;
    hit     = 1'b0;
    from_in = 1'b0;
    sel_idx = '0;
    grant   = '0;
    bypass  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!hit && hold_valid[idx]) begin
        hit     = 1'b1;
        sel_idx = idx[SRC_W-1:0];
      end
    end
`ifdef CDB_BYPASS_EN
    if (hold_valid == '0) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (!hit && in_pkt[idx].valid) begin
          hit     = 1'b1;
          from_in = 1'b1;
          sel_idx = idx[SRC_W-1:0];
        end
      end
    end
`endif
    if (squash) hit = 1'b0;
    if (hit) begin
      if (from_in) bypass[sel_idx] = 1'b1;
      else         grant[sel_idx]  = 1'b1;
    end
  end

  always_comb begin : drive_outputs
    cdb_packet    = '0;
    cdb_src       = '0;
    pending_count = '0;
    if (|grant) begin
      cdb_packet = hold_pkt[sel_idx];
      cdb_src    = sel_idx;
    end else if (|bypass) begin
      cdb_packet = in_pkt[sel_idx];
      cdb_src    = sel_idx;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      pending_count = pending_count + CNT_W'(hold_valid[i]);
    end
  end

  // Acknowledge depends only on registered state and squash, never on the presented packet.
  assign fu_written = ~hold_valid | grant | {NUM_FU{squash}};

  always_comb begin : capture_enable
    for (int i = 0; i < NUM_FU; i++) begin
      capture[i] = in_pkt[i].valid & fu_written[i] & ~bypass[i] & ~squash;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      rr_ptr     <= SRC_W'(RR_INIT);
    end else if (squash) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i])    hold_valid[i] <= 1'b1;
        else if (grant[i]) hold_valid[i] <= 1'b0;
      end
      if (|grant || |bypass) begin
        if (sel_idx == SRC_W'(NUM_FU - 1)) rr_ptr <= '0;
        else                               rr_ptr <= sel_idx + 1'b1;
      end
    end
  end

  // NOTE: payload storage is not reset; it is only observed while its valid bit is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (capture[i]) hold_pkt[i] <= in_pkt[i];
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter (default build): table of per-cycle vectors plus a per-unit
// scoreboard of accepted results, and a hand-written mid-operation reset sequence.

module tb_cdb_writeback_arbiter;
  import cdb_pkg::*;

  localparam int N = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic               squash;
  logic [N*PKT_W-1:0] fu_packet;
  logic [N-1:0]       fu_written;
  logic [PKT_W-1:0]   cdb_packet;
  logic [1:0]         cdb_src;
  logic [1:0]         pending_count;

  ex_wr_packet_t cdb;
  assign cdb = cdb_packet;

  cdb_writeback_arbiter #(.NUM_FU(N), .RR_INIT(0)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_packet     (fu_packet),
    .fu_written    (fu_written),
    .cdb_packet    (cdb_packet),
    .cdb_src       (cdb_src),
    .pending_count (pending_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  ex_wr_packet_t exp_q [N][$];

  typedef struct {
    logic       sq;
    logic [2:0] v;
    logic [4:0] t0, t1, t2;
    logic       exp_cv;
    logic [4:0] exp_tag;
    logic [1:0] exp_src;
    logic [2:0] exp_w;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] val_of(input logic [4:0] tag);
    return (tag == 5'd5) ? 32'h0000_0010 : (32'hC0DE_0000 | 32'(tag));
  endfunction

  function automatic ex_wr_packet_t mk(input logic v, input logic [4:0] tag);
    ex_wr_packet_t p;
    p.valid   = v;
    p.rob_tag = tag;
    p.value   = val_of(tag);
    return p;
  endfunction

  function automatic vec_t row(input logic sq, input logic [2:0] v, input logic [4:0] t0, t1, t2,
                               input logic cv, input logic [4:0] tag, input logic [1:0] src,
                               input logic [2:0] w, input logic [1:0] cnt);
    vec_t r;
    r.sq = sq; r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2;
    r.exp_cv = cv; r.exp_tag = tag; r.exp_src = src; r.exp_w = w; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic drive(input logic sq, input logic [2:0] v, input logic [4:0] t0, t1, t2);
    squash    = sq;
    fu_packet = {mk(v[2], t2), mk(v[1], t1), mk(v[0], t0)};
  endtask

  // Scoreboard: pop/compare whatever the CDB shows this cycle, then push the packets accepted at the coming edge.
  task automatic observe(input logic sq, input logic [2:0] v, input logic [4:0] t0, t1, t2);
    logic [4:0]    tags [N];
    ex_wr_packet_t got;
    tags[0] = t0; tags[1] = t1; tags[2] = t2;
    if (cdb.valid) begin
      if (exp_q[cdb_src].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_spurious: unit %0d broadcast tag %0d with nothing outstanding", cdb_src, cdb.rob_tag);
      end else begin
        got = exp_q[cdb_src].pop_front();
        check("sb_tag", 64'(cdb.rob_tag), 64'(got.rob_tag));
        check("sb_value", 64'(cdb.value), 64'(got.value));
      end
    end
    if (sq) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && fu_written[i]) exp_q[i].push_back(mk(1'b1, tags[i]));
      end
    end
  endtask

  initial begin
    tbl[0]  = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[1]  = row(0, 3'b111,  1,  2, 3,  0,  0, 0, 3'b111, 0);
    tbl[2]  = row(0, 3'b000,  0,  0, 0,  1,  1, 0, 3'b001, 3);
    tbl[3]  = row(0, 3'b000,  0,  0, 0,  1,  2, 1, 3'b011, 2);
    tbl[4]  = row(0, 3'b000,  0,  0, 0,  1,  3, 2, 3'b111, 1);
    tbl[5]  = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[6]  = row(0, 3'b001,  5,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[7]  = row(0, 3'b000,  0,  0, 0,  1,  5, 0, 3'b111, 1);
    tbl[8]  = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[9]  = row(0, 3'b111, 10, 11, 6,  0,  0, 0, 3'b111, 0);
    tbl[10] = row(0, 3'b100,  0,  0, 7,  1, 11, 1, 3'b010, 3);
    tbl[11] = row(0, 3'b100,  0,  0, 7,  1,  6, 2, 3'b110, 2);
    tbl[12] = row(0, 3'b000,  0,  0, 0,  1, 10, 0, 3'b011, 2);
    tbl[13] = row(0, 3'b000,  0,  0, 0,  1,  7, 2, 3'b111, 1);
    tbl[14] = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[15] = row(0, 3'b011,  4,  9, 0,  0,  0, 0, 3'b111, 0);
    tbl[16] = row(1, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 2);
    tbl[17] = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[18] = row(1, 3'b001, 12,  0, 0,  0,  0, 0, 3'b111, 0);
    tbl[19] = row(0, 3'b000,  0,  0, 0,  0,  0, 0, 3'b111, 0);

    reset     = 1'b1;
    squash    = 1'b0;
    fu_packet = '0;
    #1;
    check("reset_cdb", 64'(cdb_packet), 64'd0);
    check("reset_written", 64'(fu_written), 64'b111);
    check("reset_count", 64'(pending_count), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      check($sformatf("idle%0d_valid", c), 64'(cdb.valid), 64'd0);
      check($sformatf("idle%0d_written", c), 64'(fu_written), 64'b111);
      check($sformatf("idle%0d_count", c), 64'(pending_count), 64'd0);
    end

    for (int r = 0; r < 20; r++) begin
      @(negedge clock);
      drive(tbl[r].sq, tbl[r].v, tbl[r].t0, tbl[r].t1, tbl[r].t2);
      #1;
      if (tbl[r].exp_cv) begin
        check($sformatf("row%0d_cdb_valid", r), 64'(cdb.valid), 64'd1);
        check($sformatf("row%0d_cdb_tag", r), 64'(cdb.rob_tag), 64'(tbl[r].exp_tag));
      end else begin
        check($sformatf("row%0d_cdb_zero", r), 64'(cdb_packet), 64'd0);
      end
      check($sformatf("row%0d_cdb_src", r), 64'(cdb_src), 64'(tbl[r].exp_src));
      check($sformatf("row%0d_written", r), 64'(fu_written), 64'(tbl[r].exp_w));
      check($sformatf("row%0d_count", r), 64'(pending_count), 64'(tbl[r].exp_cnt));
      observe(tbl[r].sq, tbl[r].v, tbl[r].t0, tbl[r].t1, tbl[r].t2);
    end

    // Mid-operation asynchronous reset with two results pending.
    @(negedge clock);
    drive(0, 3'b011, 20, 21, 0);
    #1;
    observe(0, 3'b011, 20, 21, 0);
    @(negedge clock);
    drive(0, 3'b000, 0, 0, 0);
    #1;
    check("rst_pre_count", 64'(pending_count), 64'd2);
    observe(0, 3'b000, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    check("rst_cdb_zero", 64'(cdb_packet), 64'd0);
    check("rst_count", 64'(pending_count), 64'd0);
    check("rst_written", 64'(fu_written), 64'b111);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    drive(0, 3'b001, 22, 0, 0);
    #1;
    check("post_rst_accept_idle", 64'(cdb.valid), 64'd0);
    observe(0, 3'b001, 22, 0, 0);
    @(negedge clock);
    drive(0, 3'b000, 0, 0, 0);
    #1;
    check("post_rst_valid", 64'(cdb.valid), 64'd1);
    check("post_rst_tag", 64'(cdb.rob_tag), 64'd22);
    check("post_rst_src", 64'(cdb_src), 64'd0);
    observe(0, 3'b000, 0, 0, 0);
    @(negedge clock);
    #1;
    observe(0, 3'b000, 0, 0, 0);

    for (int i = 0; i < N; i++) begin
      check($sformatf("sb_drained_u%0d", i), 64'(exp_q[i].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Receiving end of the functional-unit result interface.
- Collects EX_WR_PACKET results from NUM_FU execution units (ALU, address calculation, pipelined multiplier) into one-entry holding buffers. Each cycle it grants one buffered result onto the single common data bus (CDB) to the ROB and RS.
- Returns a per-unit written acknowledge; the multiplier uses this acknowledge as mult_written, where stall = ~written.

Parameters:
- NUM_FU, 3, number of result sources; index 0 = ALU, 1 = address calc (store results), 2 = multiplier.
- RR_INIT, 0, round-robin pointer value after reset; must be < NUM_FU.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- squash  input  1  branch-misprediction flush; drops all pending results
- fu_packet  input  NUM_FU x EX_WR_PACKET  per-unit results; .valid marks a presented result
- fu_written  output  NUM_FU  per-unit acknowledge; 1 = the presented packet is taken this cycle
- cdb_packet  output  EX_WR_PACKET  broadcast result; .valid = 1 for exactly one cycle per result
- cdb_src  output  $clog2(NUM_FU)  index of the unit whose result is on cdb_packet; 0 when invalid
- pending_count  output  $clog2(NUM_FU+1)  number of occupied holding buffers

Behaviour:
- Reset: all buffers invalid; rr_ptr = RR_INIT; cdb_packet all-zero; cdb_src = 0; pending_count = 0; fu_written all 1.
- Buffers: buf[i] is one EX_WR_PACKET plus buf_valid[i], both registered.
- Grant, combinational from registered state only:
  - search buf_valid starting at rr_ptr, upward with wrap-around;
  - the first set index is granted; grant is one-hot or zero.
- CDB output, combinational:
  - if a buffer is granted: cdb_packet = buf[granted], cdb_src = granted;
  - otherwise cdb_packet = '0.
- Acknowledge: fu_written[i] = ~buf_valid[i] | grant[i]. No combinational path from fu_packet to fu_written.
- Capture at a clock edge:
  - if fu_packet[i].valid & fu_written[i]: buf[i] <= fu_packet[i], buf_valid[i] <= 1;
  - else if grant[i]: buf_valid[i] <= 0;
  - else hold.
  - A granted buffer with a new valid input is refilled in the same edge, giving back-to-back throughput of 1 per unit when uncontended.
- Packets with valid = 0 are never captured.
- fu_written is independent of fu_packet.valid. The producer must hold its packet while fu_written = 0, because the multiplier stalls.
- rr_ptr: on any grant, rr_ptr <= (granted + 1) mod NUM_FU; otherwise hold.
- Latency: a result accepted at edge t appears on the CDB in cycle t+1 at the earliest.
- Worst-case wait for any unit: NUM_FU cycles, from round-robin fairness.
- pending_count = popcount(buf_valid).
- Squash:
  - cdb_packet.valid forced 0 and cdb_src = 0 in the squash cycle;
  - fu_written all 1;
  - at the edge, all buf_valid <= 0 and inputs are ignored (not captured);
  - rr_ptr holds.
- Reset mid-operation clears buffers immediately (asynchronous). Pending results are lost, and the outputs take reset values in the same cycle.
- Simultaneous events:
  - squash has priority over capture and grant;
  - reset has priority over everything.

Optional Feature:
- CDB_BYPASS_EN, when defined:
  - if no buffer is valid and squash = 0, the first valid fu_packet (round-robin search from rr_ptr) is driven onto cdb_packet in the same cycle;
  - that packet is not captured, its fu_written = 1, and rr_ptr advances past it;
  - other valid inputs are captured normally.
  - Zero-cycle latency when idle.
- When undefined: minimum latency is exactly 1 cycle, and fu_written never depends on fu_packet.

Test Plan:
- Reset then idle, no valid inputs -> cdb_packet.valid = 0, fu_written = 3'b111, pending_count = 0 for 10 cycles.
- ALU only: valid packet rob_tag = 5, value = 32'h0000_0010 at cycle 1 -> cdb_packet.valid = 1, rob_tag = 5, value = 32'h10, cdb_src = 0 in cycle 2 (cycle 1 with CDB_BYPASS_EN).
- All three units valid in the same cycle with tags 1, 2, 3 held until acknowledged, rr_ptr = 0 -> CDB shows tags 1, 2, 3 on three consecutive cycles. fu_written = 3'b111 at acceptance. Afterwards fu_written[1] = 0 while tag 2 waits and fu_written[2] = 0 while tag 3 waits.
- Multiplier presents tag 7 while its buffer holds an ungranted tag 6 -> fu_written[2] = 0. Multiplier holds tag 7 until fu_written[2] = 1. Tag 6 is broadcast before tag 7, and no result is dropped or duplicated.
- Buffers hold tags 4 and 9, squash = 1 for one cycle -> cdb_packet.valid = 0 in that cycle, pending_count = 0 the next cycle, and neither tag is ever broadcast.
- Assert reset while pending_count = 2 -> in the same cycle cdb_packet = '0 and pending_count = 0; after reset deasserts, a new ALU packet broadcasts normally.
